// File: rtl/up_frame_pkg.sv
// up_frame_pkg: shared frame-format constants, FSM state type and drop causes for up_frame_check
package up_frame_pkg;
    localparam logic [31:0] HDR_TAG     = 32'hADF90C00;
    localparam int          PAYLOAD_LEN = 128;
    localparam int          FRAME_WORDS = 131;
    localparam int          BUF_DEPTH   = 512;

    typedef enum logic [2:0] {IDLE, SEQ, PAYLOAD, CHECK, DROP} state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_HDR  = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_OVF  = 2'd3;

    function automatic logic hdr_valid(input logic [63:0] w);
        return w[63:32] == HDR_TAG && w[31:0] >= 32'd1 && w[31:0] <= 32'd4;
    endfunction
endpackage

// File: rtl/frame_ram.sv
// frame_ram: simple dual-port 512x64 buffer with registered, enable-held read data
module frame_ram
    import up_frame_pkg::*;
(
    input  logic        fifo_rdclk,
    input  logic        we,
    input  logic [8:0]  waddr,
    input  logic [63:0] wdata,
    input  logic        re,
    input  logic [8:0]  raddr,
    output logic [63:0] rdata
);
    logic [63:0] mem [BUF_DEPTH];

    always_ff @(posedge fifo_rdclk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/up_frame_check.sv
// up_frame_check: validates upstream frames, buffers them and forwards only complete frames
// with an appended XOR trailer; malformed, mis-sized or non-fitting frames are dropped.
module up_frame_check
    import up_frame_pkg::*;
(
    input  logic        fifo_rdclk,
    input  logic        rst_n,
    input  logic        data_valid,
    input  logic [63:0] up_data,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic        out_last,
    output logic [15:0] good_cnt,
    output logic [15:0] err_cnt,
    output logic [1:0]  err_code
);
    state_t      state;
    logic [9:0]  wr_ptr, cm_ptr, rd_ptr, base, used;
    logic [63:0] csum, wq_data, ram_wdata, ram_rdata;
    logic [7:0]  pcnt, rd_idx;
    logic [8:0]  wq_addr, ram_waddr;
    logic        wq_en, ram_we, ram_re, q_v, q_last, out_adv, room;

    // Frame words are written one cycle late so a header arriving during CHECK
    // never competes with the trailer for the single write port.
    assign base      = wr_ptr + {9'd0, state == CHECK};
    assign used      = base - rd_ptr;
    assign room      = used <= 10'(BUF_DEPTH - FRAME_WORDS);
    assign ram_we    = state == CHECK || wq_en;
    assign ram_waddr = state == CHECK ? wr_ptr[8:0] : wq_addr;
    assign ram_wdata = state == CHECK ? csum : wq_data;

    always_ff @(posedge fifo_rdclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            cm_ptr   <= '0;
            csum     <= '0;
            pcnt     <= '0;
            wq_en    <= 1'b0;
            wq_addr  <= '0;
            wq_data  <= '0;
            good_cnt <= '0;
            err_cnt  <= '0;
            err_code <= ERR_NONE;
        end else begin
            wq_en   <= 1'b0;
            wq_addr <= wr_ptr[8:0];
            wq_data <= up_data;
            case (state)
                IDLE, CHECK: begin
                    if (state == CHECK) begin
                        cm_ptr   <= base;
                        good_cnt <= good_cnt + 16'd1;
                    end
                    wr_ptr <= base;
                    state  <= IDLE;
                    if (data_valid) begin
                        if (!hdr_valid(up_data)) begin
                            state    <= DROP;
                            err_code <= ERR_HDR;
                            err_cnt  <= err_cnt + 16'd1;
                        end else if (!room) begin
                            state    <= DROP;
                            err_code <= ERR_OVF;
                            err_cnt  <= err_cnt + 16'd1;
                        end else begin
                            wq_en   <= 1'b1;
                            wq_addr <= base[8:0];
                            wr_ptr  <= base + 10'd1;
                            state   <= SEQ;
                        end
                    end
                end
                SEQ: begin
                    if (data_valid) begin
                        wq_en  <= 1'b1;
                        wr_ptr <= wr_ptr + 10'd1;
                        csum   <= up_data;
                        pcnt   <= '0;
                        state  <= PAYLOAD;
                    end else begin
                        wr_ptr   <= cm_ptr;
                        err_code <= ERR_LEN;
                        err_cnt  <= err_cnt + 16'd1;
                        state    <= IDLE;
                    end
                end
                PAYLOAD: begin
                    if (data_valid && pcnt != 8'(PAYLOAD_LEN)) begin
                        wq_en  <= 1'b1;
                        wr_ptr <= wr_ptr + 10'd1;
                        csum   <= csum ^ up_data;
                        pcnt   <= pcnt + 8'd1;
                    end else if (!data_valid && pcnt == 8'(PAYLOAD_LEN)) begin
                        state <= CHECK;
                    end else begin
                        wr_ptr   <= cm_ptr;
                        err_code <= ERR_LEN;
                        err_cnt  <= err_cnt + 16'd1;
                        state    <= data_valid ? DROP : IDLE;
                    end
                end
                DROP: state <= data_valid ? DROP : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Two-stage read pipeline: the RAM read register is stage one, out_data stage two.
    assign out_adv = q_v && (!out_valid || out_ready);
    assign ram_re  = rd_ptr != cm_ptr && (!q_v || out_adv);

    always_ff @(posedge fifo_rdclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            rd_idx    <= '0;
            q_v       <= 1'b0;
            q_last    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (ram_re) begin
                rd_ptr <= rd_ptr + 10'd1;
                rd_idx <= rd_idx == 8'(FRAME_WORDS - 1) ? 8'd0 : rd_idx + 8'd1;
                q_last <= rd_idx == 8'(FRAME_WORDS - 1);
            end
            q_v <= ram_re || (q_v && !out_adv);
            if (out_adv) begin
                out_data <= ram_rdata;
                out_last <= q_last;
            end
            out_valid <= out_adv || (out_valid && !out_ready);
        end
    end

    frame_ram u_ram (
        .fifo_rdclk(fifo_rdclk),
        .we        (ram_we),
        .waddr     (ram_waddr),
        .wdata     (ram_wdata),
        .re        (ram_re),
        .raddr     (rd_ptr[8:0]),
        .rdata     (ram_rdata)
    );
endmodule

// File: doc/up_frame_check.md
UP_FRAME_CHECK -- requirements
Module: up_frame_check

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: fifo_rdclk input 1 rising-edge clock; rst_n input 1 async active-low reset.
REQ-002 SHALL have input `data_valid` (1 bit): upstream word-valid from the poll stage; no backpressure.
REQ-003 SHALL have input `up_data` (64 bits): upstream frame word, sampled when data_valid=1.
REQ-004 SHALL have input `out_ready` (1 bit): downstream accepts out_data when out_valid and out_ready are both 1.
REQ-005 SHALL have output `out_valid` (1 bit): out_data holds a valid word.
REQ-006 SHALL have output `out_data` (64 bits): forwarded frame word.
REQ-007 SHALL have output `out_last` (1 bit): out_data is the frame trailer.
REQ-008 SHALL have output `good_cnt` (16 bits): count of committed frames, wrapping.
REQ-009 SHALL have output `err_cnt` (16 bits): count of dropped frames (format, length or overflow), wrapping.
REQ-010 SHALL have output `err_code` (2 bits): cause of the last drop: 0 none, 1 header, 2 length, 3 overflow.

Function
REQ-011 SHALL treat as one input frame each maximal run of consecutive data_valid=1 cycles, laid out as follows.
- Word 0 is the header {32'hADF90C00, 32'h0000000N} with N in 1..4.
- Word 1 is the sequence word.
- Words 2..129 are the 128 payload words.
REQ-012 SHALL run the FSM states IDLE, SEQ, PAYLOAD, CHECK and DROP, reset to IDLE.
REQ-013 IDLE, data_valid=1, header valid, free space >= 131 -> SEQ, header written to buffer.
REQ-014 IDLE, data_valid=1, header tag wrong or N not in 1..4 -> DROP, with err_code=1.
REQ-015 IDLE, data_valid=1, header valid, free space < 131 -> DROP, with err_code=3, nothing written.
REQ-016 SEQ, data_valid=1 -> PAYLOAD, sequence word written, checksum initialised to the sequence word.
REQ-017 PAYLOAD SHALL write each word and XOR it into the 64-bit checksum.
REQ-018 PAYLOAD SHALL count payload words in an 8-bit counter, 0..128.
REQ-019 PAYLOAD/SEQ, data_valid=0 before 128 payload words -> rollback write pointer to committed pointer, err_code=2, IDLE.
REQ-020 PAYLOAD, data_valid=1 after 128 payload words -> rollback, err_code=2, DROP.
REQ-021 PAYLOAD, data_valid=0 with exactly 128 payload words -> CHECK.
REQ-022 CHECK SHALL write the trailer (= checksum), advance the committed pointer to include it, increment good_cnt, and go to IDLE, all in one cycle.
REQ-023 DROP SHALL ignore input until data_valid=0, then go to IDLE.
REQ-024 Each drop SHALL increment err_cnt exactly once.
REQ-025 SHALL accept a new header in the first cycle after CHECK or DROP exits, which requires a minimum inter-frame gap of 1 idle cycle.
REQ-026 SHALL hold 512x64 buffer storage with 10-bit write, committed and read pointers; free space = 512 - (wr_ptr - rd_ptr).
REQ-027 SHALL present only committed words at the output; a read is permitted only while rd_ptr != committed pointer.
REQ-028 SHALL emit output words in order: header, sequence, 128 payload, trailer.
REQ-029 SHALL assert out_last only on the trailer word.
REQ-030 SHALL hold out_data/out_last stable while out_valid=1 and out_ready=0.
REQ-031 SHALL assert out_valid for the first word of a frame within 3 cycles after the CHECK cycle, when the output path is idle.
REQ-032 SHALL sustain one word per cycle while out_ready=1.
REQ-033 Simultaneous buffer write, commit and read in one cycle SHALL be legal; free space SHALL use the pre-read rd_ptr (conservative).

Reset
REQ-034 On rst_n=0: FSM=IDLE; all pointers, checksum and payload counter 0; out_valid=0; out_last=0; out_data=0; good_cnt=0; err_cnt=0; err_code=0.
REQ-035 Reset mid-frame or mid-output SHALL discard all buffered and partial frames.
REQ-036 After reset release, the first header SHALL be accepted no earlier than the first rising edge with rst_n=1.

Structure
REQ-037 Package up_frame_pkg SHALL hold the following.
- HDR_TAG=32'hADF90C00
- PAYLOAD_LEN=128
- FRAME_WORDS=131
- BUF_DEPTH=512
- the FSM state enum
- err_code constants
REQ-038 Buffer storage SHALL be a sub-module frame_ram: simple dual-port, 512x64, 1-cycle registered read, inferable as block RAM.

Verification
REQ-039 Good frame: header ch2, seq 5, payload words i=0..127 valued i, out_ready=1 -> 131 words out; trailer = 5 ^ XOR(0..127) = 64'h5; out_last on word 131; good_cnt=1.
REQ-040 Bad header 32'hADF90C00_00000007 + 129 words -> no output; err_cnt=1; err_code=1.
REQ-041 Short frame, 100 payload words, then good ch1 frame after a 1-cycle gap -> only the ch1 frame is output; err_code=2; good_cnt=1.
REQ-042 Long frame, 129 payload words -> dropped, err_code=2; next good frame passes intact.
REQ-043 out_ready=0, 4 good frames back-to-back (gap 1) -> frames 1-3 buffered (393 words), frame 4 dropped with err_code=3; then out_ready=1 -> exactly 393 words, 3 out_last pulses.
REQ-044 rst_n pulsed low at payload word 60 with 1 frame buffered -> out_valid=0 next cycle; all counters 0; next good frame output correctly.
